// File: rtl/keypad_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_decoder_pkg
//  Purpose  : Shared game constants for the keypad front end: note encoding
//             (REST, EOF, note count), keypad key-index meanings, default
//             octave limits, the key-code type and the raw key-priority
//             function used by the scanner.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package keypad_decoder_pkg;

  // Note encoding shared with the melody/scoring path.
  localparam logic [3:0] NOTE_REST  = 4'd0;
  localparam logic [3:0] NOTE_EOF   = 4'd15;
  localparam int         NOTE_COUNT = 12;

  // Key codes are keypad indices 0..13; KEY_NONE means nothing valid held.
  typedef logic [4:0] key_code_t;

  localparam key_code_t KEY_OCT_DOWN = 5'd12;
  localparam key_code_t KEY_OCT_UP   = 5'd13;
  localparam key_code_t KEY_NONE     = 5'd31;

  localparam int OCT_MIN_DEFAULT   = 1;
  localparam int OCT_MAX_DEFAULT   = 7;
  localparam int OCT_RESET_DEFAULT = 4;

  // Lowest valid pressed index wins, so a note key always beats an octave
  // key. Indices 14 and 15 are treated as not pressed.
  function automatic key_code_t first_valid_key(input logic [15:0] pressed);
    key_code_t code;
    code = KEY_NONE;
    for (int i = 15; i >= 0; i--) begin
      if (pressed[i] && (i <= int'(KEY_OCT_UP))) begin
        code = key_code_t'(i);
      end
    end
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_decoder_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : key_debouncer
//  Purpose  : Accepts a new key code only after it has been seen on
//             DEBOUNCE_SCANS consecutive full keypad scans.
//  Ports    : clk          system clock, rising edge
//             rst          asynchronous active-high reset
//             raw_code     per-scan key code, valid when scan_done is high
//             scan_done    one-cycle strobe marking a complete scan
//             stable_code  debounced key code (KEY_NONE after reset)
//  Revision : 1.0  initial release
// ============================================================================
module key_debouncer
  import keypad_decoder_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  key_code_t raw_code,
  input  logic      scan_done,
  output key_code_t stable_code
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  key_code_t        prev_raw_q, prev_raw_d;
  key_code_t        stable_q, stable_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;

  always_comb begin
    prev_raw_d  = prev_raw_q;
    match_cnt_d = match_cnt_q;
    stable_d    = stable_q;
    if (scan_done) begin
      prev_raw_d = raw_code;
      if (raw_code == prev_raw_q) begin
        // Saturate at the target so a long hold never wraps the counter.
        if (match_cnt_q != CNT_TARGET) begin
          match_cnt_d = match_cnt_q + CNT_ONE;
        end
      end else begin
        // A differing scan counts as the first sighting of the new code.
        match_cnt_d = CNT_ONE;
      end
      if (match_cnt_d == CNT_TARGET) begin
        stable_d = raw_code;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_raw_q  <= KEY_NONE;
      match_cnt_q <= '0;
      stable_q    <= KEY_NONE;
    end else begin
      prev_raw_q  <= prev_raw_d;
      match_cnt_q <= match_cnt_d;
      stable_q    <= stable_d;
    end
  end

  assign stable_code = stable_q;

endmodule
`default_nettype wire

// File: rtl/keypad_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_decoder
//  Purpose  : Scans the 4x4 player keypad, debounces it and converts the held
//             key into the note/octave pair consumed by the scoring stage.
//  Ports    : clk            system clock, rising edge
//             rst            asynchronous active-high reset
//             row[3:0]       row drive, active-low, one row low at a time
//             col[3:0]       column sense, active-low, asynchronous
//             keypad_note    debounced note (0 = no note key held)
//             keypad_octave  current octave, MIN_OCT..MAX_OCT
//             key_pressed    high while any debounced key is held
//  Revision : 1.0  initial release
// ============================================================================
module keypad_decoder
  import keypad_decoder_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int MIN_OCT        = OCT_MIN_DEFAULT,
  parameter int MAX_OCT        = OCT_MAX_DEFAULT,
  parameter int DEFAULT_OCT    = OCT_RESET_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] row,
  input  logic [3:0] col,
  output logic [3:0] keypad_note,
  output logic [3:0] keypad_octave,
  output logic       key_pressed
);

  localparam int DWELL_W = $clog2(SCAN_DIV);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
  localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);

  // Column synchroniser
  logic [3:0] col_meta_q, col_meta_d;
  logic [3:0] col_sync_q, col_sync_d;

  // Scanner
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [1:0]         row_idx_q, row_idx_d;
  logic [15:0]        snap_q, snap_d;
  logic               row_last;
  logic               scan_done;

  // Key codes
  key_code_t raw_code;
  key_code_t stable_code;
  key_code_t last_stable_q, last_stable_d;

  // Output registers
  logic [3:0] note_q, note_d;
  logic [3:0] oct_q, oct_d;
  logic       pressed_q, pressed_d;

  always_comb begin
    col_meta_d = col;
    col_sync_d = col_meta_q;
  end

  // The dwell counter is at least 4 deep, so the synchronised column value
  // seen on the last dwell cycle always belongs to the row being driven.
  always_comb begin
    row_last  = (dwell_q == DWELL_LAST);
    scan_done = row_last && (row_idx_q == 2'd3);
    dwell_d   = dwell_q + DWELL_ONE;
    row_idx_d = row_idx_q;
    snap_d    = snap_q;
    if (row_last) begin
      dwell_d   = '0;
      row_idx_d = row_idx_q + 2'd1;
      snap_d[{row_idx_q, 2'b00} +: 4] = ~col_sync_q;
    end
    // On the scan-complete cycle snap_d already includes row 3, so the code
    // handed to the debouncer covers the whole scan.
    raw_code = first_valid_key(snap_d);
  end

  key_debouncer #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_debouncer (
    .clk         (clk),
    .rst         (rst),
    .raw_code    (raw_code),
    .scan_done   (scan_done),
    .stable_code (stable_code)
  );

  // Outputs react only to a change of the stable code, which gives exactly
  // one octave step per press and treats a direct key-to-key change as a
  // fresh press of the new key.
  always_comb begin
    last_stable_d = stable_code;
    note_d        = note_q;
    oct_d         = oct_q;
    pressed_d     = pressed_q;
    if (stable_code != last_stable_q) begin
      if (stable_code < key_code_t'(NOTE_COUNT)) begin
        note_d = stable_code[3:0] + 4'd1;
      end else begin
        note_d = NOTE_REST;
      end
      pressed_d = (stable_code != KEY_NONE);
      if ((stable_code == KEY_OCT_DOWN) && (oct_q > 4'(MIN_OCT))) begin
        oct_d = oct_q - 4'd1;
      end
      if ((stable_code == KEY_OCT_UP) && (oct_q < 4'(MAX_OCT))) begin
        oct_d = oct_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta_q    <= 4'hF;
      col_sync_q    <= 4'hF;
      dwell_q       <= '0;
      row_idx_q     <= 2'd0;
      snap_q        <= '0;
      last_stable_q <= KEY_NONE;
      note_q        <= NOTE_REST;
      oct_q         <= 4'(DEFAULT_OCT);
      pressed_q     <= 1'b0;
    end else begin
      col_meta_q    <= col_meta_d;
      col_sync_q    <= col_sync_d;
      dwell_q       <= dwell_d;
      row_idx_q     <= row_idx_d;
      snap_q        <= snap_d;
      last_stable_q <= last_stable_d;
      note_q        <= note_d;
      oct_q         <= oct_d;
      pressed_q     <= pressed_d;
    end
  end

  assign row           = ~(4'b0001 << row_idx_q);
  assign keypad_note   = note_q;
  assign keypad_octave = oct_q;
  assign key_pressed   = pressed_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_decoder
//  Purpose  : Directed self-checking bench for keypad_decoder with
//             SCAN_DIV=4 and DEBOUNCE_SCANS=3 (one scan = 16 clocks). The
//             keypad model shorts a column low while its row is driven and
//             the key is held. Stimulus is applied one clock into each scan,
//             so after a 16-clock step the outputs reflect every completed
//             scan.
//  Revision : 1.0  initial release
// ============================================================================
module tb_keypad_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  keypad_note;
  logic [3:0]  keypad_octave;
  logic        key_pressed;
  logic [15:0] keys;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
      end
    end
  end

  keypad_decoder #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (3),
    .MIN_OCT        (1),
    .MAX_OCT        (7),
    .DEFAULT_OCT    (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .row           (row),
    .col           (col),
    .keypad_note   (keypad_note),
    .keypad_octave (keypad_octave),
    .key_pressed   (key_pressed)
  );

  task automatic step_scan(input logic [15:0] k);
    keys = k;
    repeat (16) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0] exp_rows [4];
    exp_rows = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    keys = 16'h0000;
    rst  = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (row !== 4'b1110) begin errors++; $display("FAIL reset_row: got %b expected 1110", row); end
    checks++; if (keypad_note !== 4'd0) begin errors++; $display("FAIL reset_note: got %0d expected 0", keypad_note); end
    checks++; if (keypad_octave !== 4'd4) begin errors++; $display("FAIL reset_octave: got %0d expected 4", keypad_octave); end
    checks++; if (key_pressed !== 1'b0) begin errors++; $display("FAIL reset_pressed: got %b expected 0", key_pressed); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (row !== 4'b1110) begin errors++; $display("FAIL scan_row0: got %b expected 1110", row); end
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(negedge clk);
      checks++;
      if (row !== exp_rows[i]) begin errors++; $display("FAIL scan_row_step%0d: got %b expected %b", i, row, exp_rows[i]); end
    end
  endtask

  task automatic test_note_hold();
    step_scan(16'h0010);
    step_scan(16'h0010);
    checks++; if (keypad_note !== 4'd0) begin errors++; $display("FAIL hold_early_note: got %0d expected 0", keypad_note); end
    step_scan(16'h0010);
    checks++; if (keypad_note !== 4'd5) begin errors++; $display("FAIL hold_note: got %0d expected 5", keypad_note); end
    checks++; if (key_pressed !== 1'b1) begin errors++; $display("FAIL hold_pressed: got %b expected 1", key_pressed); end
    repeat (3) step_scan(16'h0010);
    checks++; if (keypad_note !== 4'd5) begin errors++; $display("FAIL hold_keep_note: got %0d expected 5", keypad_note); end
    step_scan(16'h0000);
    step_scan(16'h0000);
    checks++; if (keypad_note !== 4'd5) begin errors++; $display("FAIL release_early_note: got %0d expected 5", keypad_note); end
    step_scan(16'h0000);
    checks++; if (keypad_note !== 4'd0) begin errors++; $display("FAIL release_note: got %0d expected 0", keypad_note); end
    checks++; if (key_pressed !== 1'b0) begin errors++; $display("FAIL release_pressed: got %b expected 0", key_pressed); end
  endtask

  task automatic test_octave_steps();
    logic [3:0] exp_up [5];
    logic [3:0] exp_dn [8];
    exp_up = '{4'd5, 4'd6, 4'd7, 4'd7, 4'd7};
    exp_dn = '{4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd1, 4'd1};
    for (int p = 0; p < 5; p++) begin
      repeat (5) step_scan(16'h2000);
      checks++;
      if (keypad_octave !== exp_up[p]) begin errors++; $display("FAIL oct_up%0d: got %0d expected %0d", p, keypad_octave, exp_up[p]); end
      if (p == 0) begin
        checks++; if (keypad_note !== 4'd0) begin errors++; $display("FAIL oct_key_note: got %0d expected 0", keypad_note); end
        checks++; if (key_pressed !== 1'b1) begin errors++; $display("FAIL oct_key_pressed: got %b expected 1", key_pressed); end
      end
      repeat (5) step_scan(16'h0000);
    end
    for (int p = 0; p < 8; p++) begin
      repeat (5) step_scan(16'h1000);
      checks++;
      if (keypad_octave !== exp_dn[p]) begin errors++; $display("FAIL oct_down%0d: got %0d expected %0d", p, keypad_octave, exp_dn[p]); end
      repeat (5) step_scan(16'h0000);
    end
  endtask

  task automatic test_octave_hold();
    repeat (4) step_scan(16'h2000);
    checks++; if (keypad_octave !== 4'd5) begin errors++; $display("FAIL hold_oct_first: got %0d expected 5", keypad_octave); end
    for (int s = 0; s < 16; s++) begin
      step_scan(16'h2000);
      checks++;
      if (keypad_octave !== 4'd5) begin errors++; $display("FAIL hold_oct_scan%0d: got %0d expected 5", s, keypad_octave); end
    end
    repeat (4) step_scan(16'h0000);
    checks++; if (keypad_octave !== 4'd5) begin errors++; $display("FAIL hold_oct_release: got %0d expected 5", keypad_octave); end
    checks++; if (key_pressed !== 1'b0) begin errors++; $display("FAIL hold_oct_pressed: got %b expected 0", key_pressed); end
  endtask

  task automatic test_ignored_keys();
    repeat (5) step_scan(16'hC000);
    checks++; if (key_pressed !== 1'b0) begin errors++; $display("FAIL ignored_pressed: got %b expected 0", key_pressed); end
    checks++; if (keypad_note !== 4'd0) begin errors++; $display("FAIL ignored_note: got %0d expected 0", keypad_note); end
    step_scan(16'h0000);
  endtask

  task automatic test_bounce();
    // Toggle every 10 clocks starting released; the row-0 samples see the
    // key on two consecutive scans at most, so it must never be accepted.
    for (int t = 0; t < 80; t++) begin
      keys = (((t / 10) % 2) == 1) ? 16'h0004 : 16'h0000;
      @(negedge clk);
      if ((t % 16) == 15) begin
        checks++;
        if (keypad_note !== 4'd0) begin errors++; $display("FAIL bounce_note_t%0d: got %0d expected 0", t, keypad_note); end
      end
    end
    step_scan(16'h0004);
    step_scan(16'h0004);
    checks++; if (keypad_note !== 4'd0) begin errors++; $display("FAIL bounce_steady_early: got %0d expected 0", keypad_note); end
    step_scan(16'h0004);
    checks++; if (keypad_note !== 4'd3) begin errors++; $display("FAIL bounce_steady_note: got %0d expected 3", keypad_note); end
    repeat (4) step_scan(16'h0000);
  endtask

  task automatic test_multi_and_reset();
    repeat (3) step_scan(16'h1080);
    checks++; if (keypad_note !== 4'd8) begin errors++; $display("FAIL multi_note: got %0d expected 8", keypad_note); end
    checks++; if (keypad_octave !== 4'd5) begin errors++; $display("FAIL multi_octave: got %0d expected 5", keypad_octave); end
    checks++; if (key_pressed !== 1'b1) begin errors++; $display("FAIL multi_pressed: got %b expected 1", key_pressed); end
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (keypad_note !== 4'd0) begin errors++; $display("FAIL midreset_note: got %0d expected 0", keypad_note); end
    checks++; if (keypad_octave !== 4'd4) begin errors++; $display("FAIL midreset_octave: got %0d expected 4", keypad_octave); end
    checks++; if (key_pressed !== 1'b0) begin errors++; $display("FAIL midreset_pressed: got %b expected 0", key_pressed); end
    checks++; if (row !== 4'b1110) begin errors++; $display("FAIL midreset_row: got %b expected 1110", row); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    step_scan(16'h1080);
    step_scan(16'h1080);
    checks++; if (keypad_note !== 4'd0) begin errors++; $display("FAIL after_reset_early: got %0d expected 0", keypad_note); end
    step_scan(16'h1080);
    checks++; if (keypad_note !== 4'd8) begin errors++; $display("FAIL after_reset_note: got %0d expected 8", keypad_note); end
    checks++; if (keypad_octave !== 4'd4) begin errors++; $display("FAIL after_reset_octave: got %0d expected 4", keypad_octave); end
  endtask

  initial begin
    test_reset();
    test_note_hold();
    test_octave_steps();
    apply_reset();
    test_octave_hold();
    test_ignored_keys();
    test_bounce();
    test_multi_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
